// File: rtl/xbar_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xbar_port_arbiter (with helper onehot_detect)
// Purpose  : Round-robin arbiter for one crossbar output port. Ownership is
//            granted one cycle after a request. It is held until the owner's
//            packet ends, which is a beat with beat_fire and beat_last both
//            set. On that release the next owner is handed over with no idle
//            cycle between packets.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            req        - [NUM_REQ] request / hold bits, one per requester
//            beat_fire  - a data beat moved through the port this cycle
//            beat_last  - that beat ends the packet (qualified by beat_fire)
//            grant      - [NUM_REQ] one-hot owner, zero when idle (registered)
//            grant_id   - [IDW] binary index of grant, zero when idle
//            busy       - port currently owned
//            onehot_err - sticky: grant seen non-one-hot while busy
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// onehot_detect : combinational check that exactly one bit of vec is set.
// ----------------------------------------------------------------------------
module onehot_detect #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic             is_onehot
);
  // x & (x-1) clears the lowest set bit; zero result means at most one bit.
  assign is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
endmodule

module xbar_port_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               beat_fire,
  input  logic               beat_last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               onehot_err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [IDW-1:0]       rr_ptr, rr_ptr_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic [IDW-1:0]       grant_id_n;
  logic                 busy_n;

  logic                 release_beat;
  logic [IDW:0]         owner_inc;
  logic [IDW-1:0]       owner_next;
  logic [IDW-1:0]       start_ptr;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 found;
  logic [IDW-1:0]       offset;
  logic [IDW:0]         pick_sum;
  logic [IDW-1:0]       pick_id;
  logic [NUM_REQ-1:0]   pick_vec;
  logic                 grant_ok;

  assign release_beat = beat_fire & beat_last;

  // Index just past the current owner, wrapped; this becomes the pointer on
  // release and also seeds the same-edge search for the next owner.
  always_comb begin
    owner_inc = {1'b0, grant_id} + (IDW+1)'(1);
    if (owner_inc >= (IDW+1)'(NUM_REQ)) begin
      owner_inc = '0;
    end
    owner_next = owner_inc[IDW-1:0];
  end

  // When OWNED the search is only consumed on release, so it always starts
  // from the post-release pointer rather than the stale rr_ptr.
  assign start_ptr = (state == OWNED) ? owner_next : rr_ptr;

  // Rotate req so the highest-priority requester lands at bit 0, take the
  // first set bit, then map the offset back to an absolute index.
  always_comb begin
    req_rot  = NUM_REQ'({req, req} >> start_ptr);
    found    = 1'b0;
    offset   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = IDW'(k);
      end
    end
    pick_sum = {1'b0, start_ptr} + {1'b0, offset};
    if (pick_sum >= (IDW+1)'(NUM_REQ)) begin
      pick_sum = pick_sum - (IDW+1)'(NUM_REQ);
    end
    pick_id  = pick_sum[IDW-1:0];
    pick_vec = NUM_REQ'(1) << pick_id;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    grant_n    = grant;
    grant_id_n = grant_id;
    busy_n     = busy;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = OWNED;
          grant_n    = pick_vec;
          grant_id_n = pick_id;
          busy_n     = 1'b1;
        end
      end
      OWNED: begin
        // Owner dropping req does not end ownership; only the last beat does.
        if (release_beat) begin
          rr_ptr_n = owner_next;
          if (found) begin
            grant_n    = pick_vec;
            grant_id_n = pick_id;
          end else begin
            state_n    = IDLE;
            grant_n    = '0;
            grant_id_n = '0;
            busy_n     = 1'b0;
          end
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        grant_id_n = '0;
        busy_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      busy     <= busy_n;
    end
  end

  onehot_detect #(
    .WIDTH (NUM_REQ)
  ) u_grant_check (
    .vec       (grant),
    .is_onehot (grant_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      onehot_err <= 1'b0;
    end else if (busy && !grant_ok) begin
      onehot_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/xbar_port_arbiter.md
XBAR_PORT_ARBITER -- requirements
Module: xbar_port_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of input requesters competing for one crossbar output port; legal range 1..32.
REQ-002 Parameter IDW is derived, not user-set: max(1, clog2(NUM_REQ)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NUM_REQ  bit i high while requester i wants, or holds, the output port.
REQ-006 beat_fire  input  1  one data beat transferred through the port this cycle.
REQ-007 beat_last  input  1  the beat transferred this cycle is the packet's last; qualified by beat_fire.
REQ-008 grant  output  NUM_REQ  one-hot grant to the owning requester; all-zero when no owner.
REQ-009 grant_id  output  IDW  binary index of the set grant bit; 0 when grant is all-zero.
REQ-010 busy  output  1  high while a requester owns the port.
REQ-011 onehot_err  output  1  sticky flag: grant was observed non-one-hot while busy.

Function
REQ-012 Two states SHALL be used: IDLE (no owner) and OWNED (grant held).
REQ-013 A round-robin pointer rr_ptr (IDW bits, range 0..NUM_REQ-1) SHALL set the highest-priority index; search runs rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
REQ-014 IDLE, |req=1 at edge: next cycle grant = first set req bit found by REQ-013 search, state -> OWNED, busy=1; latency req-to-grant exactly 1 cycle.
REQ-015 IDLE, req=0: grant, grant_id, busy stay 0; beat_fire and beat_last ignored.
REQ-016 OWNED: grant SHALL be held unchanged until a cycle with beat_fire=1 and beat_last=1 (release cycle).
REQ-017 beat_last=1 with beat_fire=0 SHALL NOT release.
REQ-018 Owner deasserting req while OWNED SHALL NOT drop grant; ownership ends only at release.
REQ-019 Release cycle: rr_ptr <- (owner index + 1) mod NUM_REQ, registered at the same edge.
REQ-020 Release cycle with any req bit set (owner included): new grant chosen with the updated pointer and presented next cycle; no idle bubble; busy stays 1.
REQ-021 Release cycle with req=0: next cycle grant=0, grant_id=0, busy=0, state -> IDLE.
REQ-022 Sole requester re-requesting after release SHALL win again (pointer wrap reaches it).
REQ-023 NUM_REQ=1: grant[0] follows REQ-014..021; rr_ptr stays 0.
REQ-024 grant, grant_id, busy SHALL be registered outputs (no combinational path from req).
REQ-025 onehot_err SHALL be set the cycle after busy=1 with grant not exactly one-hot, checked with the team's one-hot detector block; cleared only by rst.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force: state IDLE, grant=0, grant_id=0, busy=0, rr_ptr=0, onehot_err=0.
REQ-027 rst asserted mid-packet SHALL abandon ownership; after rst deasserts, arbitration restarts from rr_ptr=0 per REQ-014.
REQ-028 First edge after rst deassertion is a normal IDLE cycle; req held through reset is granted one cycle after that edge.

Verification (NUM_REQ=4)
REQ-029 Reset, req=4'b0000 for 10 cycles, beat_fire toggling -> grant=0, grant_id=0, busy=0 throughout.
REQ-030 req=4'b1010 at cycle 0 -> cycle 1 grant=4'b0010, grant_id=1; three beats, beat_last on 3rd -> next cycle grant=4'b1000, grant_id=3, busy never drops.
REQ-031 req=4'b1111 constant, beat_fire=beat_last=1 every cycle -> grant sequence 0001,0010,0100,1000,0001, one per cycle, no bubble.
REQ-032 Owner 2 drops req[2] after first beat of 4-beat packet, req[0]=1 -> grant stays 4'b0100 until beat_last, then 4'b0001.
REQ-033 rst pulsed while grant=4'b1000 -> grant=0 same cycle; after release with req=4'b1111 -> grant=4'b0001.
REQ-034 All scenarios above -> onehot_err remains 0; beat_last with beat_fire=0 during OWNED -> no grant change.
